// File: rtl/out_wrapper_pkg.sv
// Shared types and constants for the FP result output wrapper.
// State encoding covers the optional flag-word states of OUT_WRAPPER_FLAGS_EN.
package out_wrapper_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int FLAG_W_DEF = 5;

    // Bit positions inside the captured exception flag field
    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_DIVZERO   = 3;
    localparam int FLAG_INVALID   = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_REL   = 3'd2,
        ST_FSEND = 3'd3,
        ST_FREL  = 3'd4
    } state_e;

    function automatic logic is_busy(input state_e s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/out_wrapper_if.sv
// Result-in / bus-out handshake bundle of the output wrapper.
// master = the wrapper, slave = FP core plus bus consumer.
interface out_wrapper_if
    import out_wrapper_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int FLAG_W = FLAG_W_DEF
);

    logic              resValid;
    logic [WIDTH-1:0]  resData;
    logic [FLAG_W-1:0] fpFlags;
    logic              resAccept;
    logic [WIDTH-1:0]  outBus;
    logic              outReady;
    logic              outAccepted;
    logic              outBusy;

    modport master (
        input  resValid,
        input  resData,
        input  fpFlags,
        input  outAccepted,
        output resAccept,
        output outBus,
        output outReady,
        output outBusy
    );

    modport slave (
        output resValid,
        output resData,
        output fpFlags,
        output outAccepted,
        input  resAccept,
        input  outBus,
        input  outReady,
        input  outBusy
    );

endinterface

// File: rtl/out_wrapper_cu.sv
// Output wrapper control: 4-phase handshake FSM and Moore decode.
// OUT_WRAPPER_FLAGS_EN adds the FSEND/FREL flag-word phase.
module out_wrapper_cu
    import out_wrapper_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic res_valid,
    input  logic out_accepted,
    output logic load,
    output logic sel_flags,
    output logic res_accept,
    output logic out_ready,
    output logic out_busy
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (res_valid) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_accepted) begin
                    state_d = ST_REL;
                end
            end
            ST_REL: begin
                if (!out_accepted) begin
`ifdef OUT_WRAPPER_FLAGS_EN
                    state_d = ST_FSEND;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef OUT_WRAPPER_FLAGS_EN
            ST_FSEND: begin
                if (out_accepted) begin
                    state_d = ST_FREL;
                end
            end
            ST_FREL: begin
                if (!out_accepted) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Only IDLE takes a result, so a held word is never overwritten
    assign res_accept = (state_q == ST_IDLE);
    assign load       = res_accept & res_valid;
    assign out_busy   = is_busy(state_q);

`ifdef OUT_WRAPPER_FLAGS_EN
    assign out_ready = (state_q == ST_SEND) | (state_q == ST_FSEND);
    assign sel_flags = (state_q == ST_FSEND) | (state_q == ST_FREL);
`else
    assign out_ready = (state_q == ST_SEND);
    assign sel_flags = 1'b0;
`endif

endmodule

// File: rtl/out_wrapper_dp.sv
// Output wrapper datapath: result/flag capture registers and outBus mux.
// Flag register exists only with OUT_WRAPPER_FLAGS_EN.
module out_wrapper_dp
    import out_wrapper_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int FLAG_W = FLAG_W_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              sel_flags,
    input  logic [WIDTH-1:0]  res_data,
    input  logic [FLAG_W-1:0] fp_flags,
    output logic [WIDTH-1:0]  out_bus
);

    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;

    always_comb begin
        res_d = res_q;
        if (load) begin
            res_d = res_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

`ifdef OUT_WRAPPER_FLAGS_EN
    logic [FLAG_W-1:0] flag_q;
    logic [FLAG_W-1:0] flag_d;

    always_comb begin
        flag_d = flag_q;
        if (load) begin
            flag_d = fp_flags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= '0;
        end else begin
            flag_q <= flag_d;
        end
    end

    // Flag word is zero-extended into the low bits of the bus
    assign out_bus = sel_flags ? {{(WIDTH-FLAG_W){1'b0}}, flag_q}
                               : res_q;
`else
    logic unused_dp;
    assign unused_dp = ^{fp_flags, sel_flags};
    assign out_bus   = res_q;
`endif

endmodule

// File: rtl/out_wrapper.sv
// Output-side wrapper of the FP datapath: result capture to 4-phase outBus.
// Optional flag word after each result: define OUT_WRAPPER_FLAGS_EN.
module out_wrapper
    import out_wrapper_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int FLAG_W = FLAG_W_DEF
)(
    input  logic       clk,
    input  logic       rst,
    out_wrapper_if.master bus
);

    logic             load;
    logic             sel_flags;
    logic             res_accept;
    logic             out_ready;
    logic             out_busy;
    logic [WIDTH-1:0] out_bus;

    out_wrapper_cu u_cu (
        .clk          (clk),
        .rst          (rst),
        .res_valid    (bus.resValid),
        .out_accepted (bus.outAccepted),
        .load         (load),
        .sel_flags    (sel_flags),
        .res_accept   (res_accept),
        .out_ready    (out_ready),
        .out_busy     (out_busy)
    );

    out_wrapper_dp #(
        .WIDTH  (WIDTH),
        .FLAG_W (FLAG_W)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .sel_flags (sel_flags),
        .res_data  (bus.resData),
        .fp_flags  (bus.fpFlags),
        .out_bus   (out_bus)
    );

    assign bus.resAccept = res_accept;
    assign bus.outReady  = out_ready;
    assign bus.outBusy   = out_busy;
    assign bus.outBus    = out_bus;

endmodule

// File: tb/tb_out_wrapper.sv
// Directed, table-driven bench for out_wrapper (both flag-build variants).
// Hand-written sequences cover asynchronous reset in the middle of SEND.
module tb_out_wrapper;

    logic clk;
    logic rst;

    out_wrapper_if #(.WIDTH(32), .FLAG_W(5)) bus ();

    out_wrapper dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] d;
        logic [4:0]  f;
        logic        acc;
        logic        e_ready;
        logic        e_accept;
        logic        e_busy;
        logic [31:0] e_bus;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic r, input logic a,
                             input logic b, input logic [31:0] w);
        chk("outReady", idx, {31'b0, bus.outReady}, {31'b0, r});
        chk("resAccept", idx, {31'b0, bus.resAccept}, {31'b0, a});
        chk("outBusy", idx, {31'b0, bus.outBusy}, {31'b0, b});
        chk("outBus", idx, bus.outBus, w);
    endtask

    task automatic add(input logic rv, input logic [31:0] d,
                       input logic [4:0] f, input logic acc,
                       input logic er, input logic ea,
                       input logic eb, input logic [31:0] ew);
        vec_t v;
        v.rv = rv; v.d = d; v.f = f; v.acc = acc;
        v.e_ready = er; v.e_accept = ea; v.e_busy = eb; v.e_bus = ew;
        vq.push_back(v);
    endtask

    // Finish a word from REL: drop outAccepted, then the flag word if built
    task automatic add_ret(input logic rv, input logic [31:0] d,
                           input logic [31:0] held, input logic [4:0] fl);
`ifdef OUT_WRAPPER_FLAGS_EN
        add(rv, d, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, {27'd0, fl});
        add(rv, d, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, {27'd0, fl});
        add(rv, d, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, held);
`else
        add(rv, d, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, held);
`endif
    endtask

    initial begin
        rst             = 1'b1;
        bus.resValid    = 1'b0;
        bus.resData     = '0;
        bus.fpFlags     = '0;
        bus.outAccepted = 1'b0;

        // Reset state
        #12;
        check_all(1000, 1'b0, 1'b1, 1'b0, 32'h0);
        rst = 1'b0;

        // Reset in the middle of SEND aborts in the same cycle
        bus.resValid = 1'b1;
        bus.resData  = 32'hDEADBEEF;
        bus.fpFlags  = 5'b10011;
        @(posedge clk); #1;
        check_all(1001, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
        bus.resValid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check_all(1002, 1'b0, 1'b1, 1'b0, 32'h0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_all(1003, 1'b0, 1'b1, 1'b0, 32'h0);

        // Single word, consumer acks after two cycles
        add(1, 32'h3F800000, 5'd0, 0, 1, 0, 1, 32'h3F800000);
        add(0, 32'h0, 5'd0, 0, 1, 0, 1, 32'h3F800000);
        add(0, 32'h0, 5'd0, 0, 1, 0, 1, 32'h3F800000);
        add(0, 32'h0, 5'd0, 1, 0, 0, 1, 32'h3F800000);
        add_ret(0, 32'h0, 32'h3F800000, 5'd0);

        // Slow consumer, second result ignored while held
        add(1, 32'hA5A5A5A5, 5'd0, 0, 1, 0, 1, 32'hA5A5A5A5);
        add(0, 32'h0, 5'd0, 1, 0, 0, 1, 32'hA5A5A5A5);
        for (int i = 0; i < 4; i++)
            add(1, 32'h40000000, 5'd0, 1, 0, 0, 1, 32'hA5A5A5A5);
        add_ret(0, 32'h0, 32'hA5A5A5A5, 5'd0);

        // Back-to-back with resValid held high
        add(1, 32'h40490FDB, 5'd0, 0, 1, 0, 1, 32'h40490FDB);
        add(1, 32'hC0000000, 5'd0, 1, 0, 0, 1, 32'h40490FDB);
        add_ret(1, 32'hC0000000, 32'h40490FDB, 5'd0);
        add(1, 32'hC0000000, 5'd0, 0, 1, 0, 1, 32'hC0000000);
        add(0, 32'h0, 5'd0, 1, 0, 0, 1, 32'hC0000000);
        add_ret(0, 32'h0, 32'hC0000000, 5'd0);

        // outAccepted while IDLE has no effect
        add(0, 32'h0, 5'd0, 1, 0, 1, 0, 32'hC0000000);
        add(0, 32'h0, 5'd0, 1, 0, 1, 0, 32'hC0000000);

        // Result with flags: flag word follows only in the flag build
        add(1, 32'h7F800000, 5'b00101, 0, 1, 0, 1, 32'h7F800000);
        add(0, 32'h0, 5'd0, 1, 0, 0, 1, 32'h7F800000);
        add_ret(0, 32'h0, 32'h7F800000, 5'b00101);
        add(0, 32'h0, 5'd0, 0, 0, 1, 0, 32'h7F800000);

        foreach (vq[i]) begin
            bus.resValid    = vq[i].rv;
            bus.resData     = vq[i].d;
            bus.fpFlags     = vq[i].f;
            bus.outAccepted = vq[i].acc;
            @(posedge clk); #1;
            check_all(i, vq[i].e_ready, vq[i].e_accept,
                      vq[i].e_busy, vq[i].e_bus);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
